// File: rtl/exec_ctrl_pkg.sv
// rtl/exec_ctrl_pkg.sv - shared types and default constants for the execution step controller
//   state_t : 2-bit FSM encoding (IDLE=0, RUN=1, STEP=2, HALT=3), visible on state_o
//   DEF_*   : default parameter values for the controller and debouncer
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam int DEF_DIV_CYCLES      = 100_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_HALT_IDLE_TICKS = 4;
    localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - pushbutton synchronizer, stable-level debouncer and rising-edge pulse
//   clk      in  system clock
//   n_rst    in  asynchronous active-low reset
//   btn_raw  in  asynchronous pushbutton, active high
//   step_req out one-cycle pulse on each debounced rising edge
module btn_debouncer
    import exec_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn_raw,
    output logic step_req
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // The counter measures how long the synchronized input has disagreed with
    // the debounced level; any agreement restarts the measurement, so a glitch
    // shorter than DEBOUNCE_CYCLES never reaches the level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
                // Only a 0->1 level change is a step request.
                r_rise  <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign step_req = r_rise;

endmodule

// File: rtl/exec_step_controller.sv
// rtl/exec_step_controller.sv - advance-enable sequencer for the dual-issue datapath
//   clk, n_rst                 clock, asynchronous active-low reset
//   btn_raw, run_mode          step pushbutton, 1=free-run / 0=single-step
//   clear_halt                 pulse that leaves HALT
//   nothing_filled             instruction queue empty flag (idle detection)
//   slot0_valid, slot1_valid   issue slot occupancy
//   freeze1/2, dp1/2_enable    scheduler controls for write qualification
//   adv_tick                   registered one-cycle pipeline advance enable
//   we1, we2                   qualified register-file write enables
//   retired_cnt                saturating count of committed writes
//   halted, state_o            HALT indicator and raw FSM state
module exec_step_controller
    import exec_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES      = DEF_DIV_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HALT_IDLE_TICKS = DEF_HALT_IDLE_TICKS,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             btn_raw,
    input  logic             run_mode,
    input  logic             clear_halt,
    input  logic             nothing_filled,
    input  logic             slot0_valid,
    input  logic             slot1_valid,
    input  logic             freeze1,
    input  logic             freeze2,
    input  logic             dp1_enable,
    input  logic             dp2_enable,
    output logic             adv_tick,
    output logic             we1,
    output logic             we2,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted,
    output logic [1:0]       state_o
);

    localparam int DIV_W  = $clog2(DIV_CYCLES);
    localparam int IDLE_W = $clog2(HALT_IDLE_TICKS + 1);

    state_t            r_state;
    state_t            w_next;
    logic [DIV_W-1:0]  r_div;
    logic [IDLE_W-1:0] r_idle;
    logic              r_adv;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_step_req;
    logic              w_div_wrap;
    logic              w_halt_cond;
    logic              w_we1;
    logic              w_we2;
    logic [CNT_W:0]    w_sum;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .clk      (clk),
        .n_rst    (n_rst),
        .btn_raw  (btn_raw),
        .step_req (w_step_req)
    );

    assign w_div_wrap  = (r_div == DIV_W'(DIV_CYCLES - 1));
    assign w_halt_cond = (r_idle == IDLE_W'(HALT_IDLE_TICKS));

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the halt condition outranks a run_mode change.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = run_mode ? ST_RUN : ST_STEP;
            ST_RUN: begin
                if (w_halt_cond)    w_next = ST_HALT;
                else if (!run_mode) w_next = ST_STEP;
            end
            ST_STEP: begin
                if (w_halt_cond)    w_next = ST_HALT;
                else if (run_mode)  w_next = ST_RUN;
            end
            ST_HALT: begin
                if (clear_halt)     w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        halted  = (r_state == ST_HALT);
        state_o = r_state;
    end

    // Divider only runs while staying in RUN, so every entry into RUN starts
    // a full DIV_CYCLES period.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_div <= '0;
        end else if (r_state == ST_RUN && w_next == ST_RUN) begin
            r_div <= w_div_wrap ? '0 : r_div + 1'b1;
        end else begin
            r_div <= '0;
        end
    end

    // The tick is decided from the current state, so a tick due on the edge
    // that leaves RUN for STEP still fires. Button pulses outside STEP are
    // simply dropped.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_adv <= 1'b0;
        end else begin
            r_adv <= (w_next != ST_HALT) &&
                     ((r_state == ST_RUN  && w_div_wrap) ||
                      (r_state == ST_STEP && w_step_req));
        end
    end

    // Idle-tick counter: sampled on tick cycles, frozen in HALT until released.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_idle <= '0;
        end else if (r_state == ST_HALT) begin
            if (clear_halt) r_idle <= '0;
        end else if (r_adv) begin
            if (!nothing_filled)  r_idle <= '0;
            else if (!w_halt_cond) r_idle <= r_idle + 1'b1;
        end
    end

    // A write commits unless its slot is empty or frozen without an enable.
    assign w_we1 = r_adv & slot0_valid & (dp1_enable | ~freeze1);
    assign w_we2 = r_adv & slot1_valid & (dp2_enable | ~freeze2);

    // One extra bit catches the carry so the count clamps instead of wrapping.
    assign w_sum = {1'b0, r_cnt} + {{CNT_W{1'b0}}, w_we1} + {{CNT_W{1'b0}}, w_we2};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        end
    end

    assign adv_tick    = r_adv;
    assign we1         = w_we1;
    assign we2         = w_we2;
    assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_exec_step_controller.sv
// tb/tb_exec_step_controller.sv - scoreboard bench for exec_step_controller
module tb_exec_step_controller;

    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int HIT = 2;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic btn_raw = 1'b0;
    logic run_mode = 1'b1;
    logic clear_halt = 1'b0;
    logic nothing_filled = 1'b0;
    logic slot0_valid = 1'b1;
    logic slot1_valid = 1'b1;
    logic freeze1 = 1'b0;
    logic freeze2 = 1'b0;
    logic dp1_enable = 1'b0;
    logic dp2_enable = 1'b0;
    logic adv_tick;
    logic we1;
    logic we2;
    logic [CW-1:0] retired_cnt;
    logic halted;
    logic [1:0] state_o;

    typedef struct {
        int we1;
        int we2;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int model_cnt = 0;

    exec_step_controller #(
        .DIV_CYCLES      (DIV),
        .DEBOUNCE_CYCLES (DEB),
        .HALT_IDLE_TICKS (HIT),
        .CNT_W           (CW)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .btn_raw        (btn_raw),
        .run_mode       (run_mode),
        .clear_halt     (clear_halt),
        .nothing_filled (nothing_filled),
        .slot0_valid    (slot0_valid),
        .slot1_valid    (slot1_valid),
        .freeze1        (freeze1),
        .freeze2        (freeze2),
        .dp1_enable     (dp1_enable),
        .dp2_enable     (dp2_enable),
        .adv_tick       (adv_tick),
        .we1            (we1),
        .we2            (we2),
        .retired_cnt    (retired_cnt),
        .halted         (halted),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Tick monitor: every observed tick must match the oldest expectation.
    always @(negedge clk) begin
        if (n_rst && adv_tick) begin
            if (q.size() == 0) begin
                chk("spurious_tick", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("tick_cyc", cyc, mon_e.cyc);
                chk("tick_we1", int'(we1), mon_e.we1);
                chk("tick_we2", int'(we2), mon_e.we2);
                chk("cnt_pre", int'(retired_cnt), model_cnt);
                model_cnt = model_cnt + mon_e.we1 + mon_e.we2;
                if (model_cnt > CNT_MAX) model_cnt = CNT_MAX;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            cycles(1);
            k++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Button press: debounced tick expected 2 + DEB + 2 cycles after the rise.
    task automatic press(input int hold, input bit expect_tick, input int e1, input int e2);
        if (expect_tick) q.push_back('{e1, e2, cyc + 2 + DEB + 2});
        btn_raw = 1'b1;
        cycles(hold);
        btn_raw = 1'b0;
        cycles(15);
        drain(5);
    endtask

    initial begin
        cycles(3);
        chk("rst_state", int'(state_o), 0);
        chk("rst_adv", int'(adv_tick), 0);
        chk("rst_we1", int'(we1), 0);
        chk("rst_we2", int'(we2), 0);
        chk("rst_cnt", int'(retired_cnt), 0);
        chk("rst_halted", int'(halted), 0);

        // Free-run from reset: ticks every DIV cycles, count saturates.
        for (int i = 0; i < 9; i++) q.push_back('{1, 1, cyc + 1 + 1 + (DIV - 1) + DIV * i});
        n_rst = 1'b1;
        #1;
        chk("idle_after_rst", int'(state_o), 0);
        cycles(1);
        chk("run_state", int'(state_o), 1);
        drain(60);
        cycles(1);
        chk("sat_cnt", int'(retired_cnt), CNT_MAX);

        // Reset in the cycle before a scheduled tick.
        cycles(2);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_adv", int'(adv_tick), 0);
        chk("rst_mid_we1", int'(we1), 0);
        chk("rst_mid_we2", int'(we2), 0);
        chk("rst_mid_cnt", int'(retired_cnt), 0);
        chk("rst_mid_state", int'(state_o), 0);
        cycles(2);
        chk("rst_hold_adv", int'(adv_tick), 0);
        chk("rst_hold_state", int'(state_o), 0);
        model_cnt = 0;
        run_mode = 1'b0;
        n_rst = 1'b1;
        #1;
        chk("idle_after_rst2", int'(state_o), 0);
        cycles(1);
        chk("step_state", int'(state_o), 2);

        // Single step: clean press, glitch, long hold.
        press(10, 1'b1, 1, 1);
        press(2, 1'b0, 0, 0);
        press(50, 1'b1, 1, 1);
        chk("step_cnt", int'(retired_cnt), 4);

        clear_halt = 1'b1;
        cycles(1);
        clear_halt = 1'b0;
        chk("clear_outside_halt", int'(state_o), 2);

        // Write qualification.
        freeze1 = 1'b1;
        dp1_enable = 1'b0;
        press(10, 1'b1, 0, 1);
        chk("qual_cnt1", int'(retired_cnt), 5);
        slot0_valid = 1'b0;
        freeze1 = 1'b0;
        dp1_enable = 1'b1;
        slot1_valid = 1'b0;
        press(10, 1'b1, 0, 0);
        chk("qual_cnt2", int'(retired_cnt), 5);
        slot0_valid = 1'b1;
        freeze1 = 1'b1;
        press(10, 1'b1, 1, 0);
        chk("qual_cnt3", int'(retired_cnt), 6);
        slot1_valid = 1'b1;
        freeze1 = 1'b0;
        dp1_enable = 1'b0;

        // Idle detection and HALT.
        nothing_filled = 1'b1;
        press(10, 1'b1, 1, 1);
        chk("one_idle_tick", int'(state_o), 2);
        q.push_back('{1, 1, cyc + 2 + DEB + 2});
        btn_raw = 1'b1;
        cycles(2 + DEB + 2);
        drain(3);
        cycles(1);
        chk("pre_halt_state", int'(state_o), 2);
        cycles(1);
        chk("halt_state", int'(state_o), 3);
        chk("halt_flag", int'(halted), 1);
        btn_raw = 1'b0;
        cycles(12);
        run_mode = 1'b1;
        press(10, 1'b0, 0, 0);
        chk("halt_hold_state", int'(state_o), 3);
        chk("halt_hold_cnt", int'(retired_cnt), 10);
        nothing_filled = 1'b0;

        q.push_back('{1, 1, cyc + 1 + 1 + 1 + (DIV - 1)});
        clear_halt = 1'b1;
        cycles(1);
        clear_halt = 1'b0;
        chk("clear_to_idle", int'(state_o), 0);
        chk("clear_unhalted", int'(halted), 0);
        cycles(1);
        chk("clear_to_run", int'(state_o), 1);
        drain(20);
        cycles(1);
        chk("final_cnt", int'(retired_cnt), 12);
        run_mode = 1'b0;
        cycles(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
